// File: rtl/key_debounce_array.sv
// N-channel key conditioner: synchronise, debounce, and emit
// press / release / long-press / auto-repeat pulses per channel.
module key_debounce_array #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = (REPEAT_CYCLES > 0) ?
                      $clog2(REPEAT_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST =
    (REPEAT_CYCLES > 0) ? RW'(REPEAT_CYCLES - 1) : '0;

  // Idle pin level, so a reset synchroniser looks released.
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {REL, PRS, HLD} state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          val_q;
    logic [DW-1:0] db_cnt;
    logic          acc;
    state_t        state;
    state_t        state_n;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_n;
    logic [RW-1:0] rep;
    logic [RW-1:0] rep_n;
    logic          prs_n;
    logic          rls_n;
    logic          lng_n;
    logic          rpt_n;
    logic          prs_q;
    logic          rls_q;
    logic          lng_q;
    logic          rpt_q;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1 <= REL_LVL;
        s2 <= REL_LVL;
      end else begin
        s1 <= key[i];
        s2 <= s1;
      end
    end

    assign lvl = (ACTIVE_LOW != 0) ? ~s2 : s2;

    // A change is accepted on its DEBOUNCE_CYCLES-th consecutive sample.
    assign acc = (lvl != val_q) && (db_cnt == DB_LAST);

    // Consecutive-sample counter; any agreeing sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt <= '0;
        val_q  <= 1'b0;
      end else if (lvl == val_q) begin
        db_cnt <= '0;
      end else if (acc) begin
        db_cnt <= '0;
        val_q  <= lvl;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end

    // Press/hold state, hold and repeat counters.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= REL;
        hold  <= '0;
        rep   <= '0;
      end else begin
        state <= state_n;
        hold  <= hold_n;
        rep   <= rep_n;
      end
    end

    // Next state and event pulses; release beats long/repeat.
    always_comb begin
      state_n = state;
      hold_n  = hold;
      rep_n   = rep;
      prs_n   = 1'b0;
      rls_n   = 1'b0;
      lng_n   = 1'b0;
      rpt_n   = 1'b0;
      unique case (state)
        REL: begin
          if (acc) begin
            state_n = PRS;
            prs_n   = 1'b1;
            hold_n  = '0;
          end
        end
        PRS: begin
          if (acc) begin
            state_n = REL;
            rls_n   = 1'b1;
            hold_n  = '0;
          end else if (hold == HOLD_LAST) begin
            state_n = HLD;
            lng_n   = 1'b1;
            hold_n  = '0;
            rep_n   = '0;
          end else begin
            hold_n = hold + HW'(1);
          end
        end
        HLD: begin
          if (acc) begin
            state_n = REL;
            rls_n   = 1'b1;
            rep_n   = '0;
          end else if (REPEAT_CYCLES != 0) begin
            if (rep == REP_LAST) begin
              rpt_n = 1'b1;
              rep_n = '0;
            end else begin
              rep_n = rep + RW'(1);
            end
          end
        end
        default: begin
          state_n = REL;
          hold_n  = '0;
          rep_n   = '0;
        end
      endcase
    end

    // Registered one-cycle event pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prs_q <= 1'b0;
        rls_q <= 1'b0;
        lng_q <= 1'b0;
        rpt_q <= 1'b0;
      end else begin
        prs_q <= prs_n;
        rls_q <= rls_n;
        lng_q <= lng_n;
        rpt_q <= rpt_n;
      end
    end

    assign key_value[i]   = val_q;
    assign key_press[i]   = prs_q;
    assign key_release[i] = rls_q;
    assign key_long[i]    = lng_q;
    assign key_repeat[i]  = rpt_q;
  end

endmodule
